// File: rtl/bcd_sum_display.sv
// ---------------------------------------------------------------------------
// bcd_sum_display
//
// Takes a 17-bit BCD sum (carry digit plus four BCD digits) through a
// valid/ready handshake, holds it in a pending buffer and copies it to the
// display buffer only at frame boundaries. The five digits are time-multiplexed
// onto one seven-segment bus. Each digit slot starts with a few dark cycles to
// stop ghosting, and leading zeros can be blanked.
//
// Optional feature macro: BCD_DISP_DP_EN
//   When defined, the block gains a decimal-point position input and a dp
//   output. The position travels through the buffers with the sum.
//
// Parameters:
//   DIV_MAX   cycles per digit slot minus one
//   GAP       dark cycles at the start of each slot
//   BLANK_LZ  1 = blank leading zeros, 0 = show all five digits
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_sum      [16] carry, [15:12] thousands .. [3:0] ones
//   in_valid    in_sum is valid this cycle
//   in_dp_pos   decimal point digit position (BCD_DISP_DP_EN only)
//   in_ready    pending buffer is empty
//   seg         segments a..g on seg[0]..seg[6], active-high
//   an          one-hot digit enable, an[0] = ones .. an[4] = carry
//   dp          decimal point segment (BCD_DISP_DP_EN only)
//   err         displayed value holds a nibble above 9
//   frame_done  one-cycle pulse after each frame boundary
// ---------------------------------------------------------------------------
module bcd_sum_display #(
   parameter int unsigned DIV_MAX  = 49999,
   parameter int unsigned GAP      = 2,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [16:0] in_sum,
   input  logic        in_valid,
`ifdef BCD_DISP_DP_EN
   input  logic [2:0]  in_dp_pos,
   output logic        dp,
`endif
   output logic        in_ready,
   output logic [6:0]  seg,
   output logic [4:0]  an,
   output logic        err,
   output logic        frame_done
);

   typedef enum logic {
      SLOT_GAP,
      SLOT_SHOW
   } slot_t;

   localparam logic [19:0] DIV_MAX_C = 20'(DIV_MAX);
   localparam logic [19:0] GAP_C     = 20'(GAP);
   // With no gap configured, every slot begins directly in SHOW.
   localparam slot_t SLOT_START = (GAP == 0) ? SLOT_SHOW : SLOT_GAP;

   logic [19:0]      prescaler;
   logic [2:0]       idx;
   logic             tick;
   logic             boundary;

   logic [16:0]      pending;
   logic             pending_full;
   logic [16:0]      disp;
   logic             accept;

   slot_t            state;
   slot_t            state_next;

   logic [4:0][3:0]  digits;
   logic [4:0]       significant;
   logic [4:0]       keep;
   logic [3:0]       cur_digit;
   logic             cur_keep;

   logic [6:0]       seg_next;
   logic [4:0]       an_next;

`ifdef BCD_DISP_DP_EN
   logic [2:0]       dp_pend;
   logic [2:0]       dp_disp;
   logic             dp_next;
`endif

   function automatic logic [6:0] encode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   function automatic logic has_bad_nibble(input logic [15:0] v);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (v[4*k +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   assign tick     = (prescaler == DIV_MAX_C);
   assign boundary = tick && (idx == 3'd4);
   assign in_ready = !pending_full;
   assign accept   = in_valid && in_ready;

   // Slot timing: prescaler divides a slot, idx walks the five digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler <= '0;
         idx       <= '0;
      end else if (tick) begin
         prescaler <= '0;
         idx       <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      end else begin
         prescaler <= prescaler + 20'd1;
      end
   end

   // Double buffer. Accept and transfer never collide: accepting needs an
   // empty pending buffer, transferring needs a full one. A sum accepted on
   // the boundary cycle therefore waits for the next boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending      <= '0;
         pending_full <= 1'b0;
         disp         <= '0;
         err          <= 1'b0;
`ifdef BCD_DISP_DP_EN
         dp_pend      <= '0;
         dp_disp      <= '0;
`endif
      end else if (boundary && pending_full) begin
         disp         <= pending;
         pending_full <= 1'b0;
         err          <= has_bad_nibble(pending[15:0]);
`ifdef BCD_DISP_DP_EN
         dp_disp      <= dp_pend;
`endif
      end else if (accept) begin
         pending      <= in_sum;
         pending_full <= 1'b1;
`ifdef BCD_DISP_DP_EN
         dp_pend      <= in_dp_pos;
`endif
      end
   end

   // Slot FSM state register; the state describes the current prescaler value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SLOT_START;
      else     state <= state_next;
   end

   // Slot FSM next state: dark for the first GAP cycles of each slot.
   always_comb begin
      state_next = state;
      if (tick) begin
         state_next = SLOT_START;
      end else if ((prescaler + 20'd1) >= GAP_C) begin
         state_next = SLOT_SHOW;
      end
   end

   assign digits = {{3'b000, disp[16]}, disp[15:0]};

   // A digit counts as significant if it is nonzero or holds the point;
   // everything above the highest significant digit is blanked.
   always_comb begin
      significant = '0;
      for (int k = 0; k < 5; k++) begin
         significant[k] = (digits[k] != 4'd0);
      end
`ifdef BCD_DISP_DP_EN
      if (dp_disp < 3'd5) significant[dp_disp] = 1'b1;
`endif
   end

   always_comb begin
      keep    = '0;
      keep[4] = significant[4];
      for (int k = 3; k >= 0; k--) begin
         keep[k] = keep[k+1] | significant[k];
      end
      keep[0] = 1'b1;
      if (!BLANK_LZ) keep = 5'b11111;
   end

   always_comb begin
      cur_digit = digits[0];
      cur_keep  = keep[0];
      case (idx)
         3'd1: begin cur_digit = digits[1]; cur_keep = keep[1]; end
         3'd2: begin cur_digit = digits[2]; cur_keep = keep[2]; end
         3'd3: begin cur_digit = digits[3]; cur_keep = keep[3]; end
         3'd4: begin cur_digit = digits[4]; cur_keep = keep[4]; end
         default: ;
      endcase
   end

   // Slot FSM outputs, registered below for one cycle of latency.
   always_comb begin
      seg_next = '0;
      an_next  = '0;
`ifdef BCD_DISP_DP_EN
      dp_next  = 1'b0;
`endif
      if (state == SLOT_SHOW && cur_keep) begin
         an_next  = 5'b00001 << idx;
         seg_next = encode(cur_digit);
`ifdef BCD_DISP_DP_EN
         dp_next  = (dp_disp == idx);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg        <= '0;
         an         <= '0;
         frame_done <= 1'b0;
`ifdef BCD_DISP_DP_EN
         dp         <= 1'b0;
`endif
      end else begin
         seg        <= seg_next;
         an         <= an_next;
         frame_done <= boundary;
`ifdef BCD_DISP_DP_EN
         dp         <= dp_next;
`endif
      end
   end

endmodule

// File: tb/tb_bcd_sum_display.sv
// ---------------------------------------------------------------------------
// tb_bcd_sum_display
//
// Self-checking bench for bcd_sum_display with DIV_MAX=3 and GAP=1, which
// gives 4-cycle slots and 20-cycle frames. The reference model tracks the
// position inside the frame as a single number and works out the expected
// display from the buffered sum with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_bcd_sum_display;

   localparam int DIVM  = 3;
   localparam int GAPC  = 1;
   localparam int SLOT  = DIVM + 1;
   localparam int FRAME = 5 * SLOT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [16:0] in_sum = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  seg;
   logic [4:0]  an;
   logic        err;
   logic        frame_done;
`ifdef BCD_DISP_DP_EN
   logic        dp;
`endif

   int numChecks = 0;
   int numErrors = 0;
   bit chkEn = 1'b0;

   bcd_sum_display #(
      .DIV_MAX  (DIVM),
      .GAP      (GAPC),
      .BLANK_LZ (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_sum     (in_sum),
      .in_valid   (in_valid),
`ifdef BCD_DISP_DP_EN
      .in_dp_pos  (3'd7),
      .dp         (dp),
`endif
      .in_ready   (in_ready),
      .seg        (seg),
      .an         (an),
      .err        (err),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Reference model state.
   int          mPos;
   bit          mFull;
   logic [16:0] mPend;
   logic [16:0] mDisp;
   bit          mErr;
   logic [6:0]  expSeg;
   logic [4:0]  expAn;
   bit          expFd;
   int          mSlot, mPhase, mTop;
   bit          mAcc;

   logic [6:0] segTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                                 7'h40, 7'h40, 7'h40, 7'h40};

   function automatic int digitOf(input logic [16:0] v, input int k);
      if (k == 4) return int'(v[16]);
      return int'(v[4*k +: 4]);
   endfunction

   function automatic bit hasBad(input logic [16:0] v);
      for (int k = 0; k < 4; k++) begin
         if (digitOf(v, k) > 9) return 1'b1;
      end
      return 1'b0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mPos   = 0;
         mFull  = 1'b0;
         mPend  = '0;
         mDisp  = '0;
         mErr   = 1'b0;
         expSeg = '0;
         expAn  = '0;
         expFd  = 1'b0;
      end else begin
         mSlot  = mPos / SLOT;
         mPhase = mPos % SLOT;
         mTop   = 0;
         for (int k = 0; k < 5; k++) begin
            if (digitOf(mDisp, k) != 0) mTop = k;
         end
         if (mPhase < GAPC || mSlot > mTop) begin
            expAn  = '0;
            expSeg = '0;
         end else begin
            expAn  = 5'(1 << mSlot);
            expSeg = segTable[digitOf(mDisp, mSlot)];
         end
         expFd = (mPos == FRAME - 1);
         mAcc  = in_valid && !mFull;
         if (mPos == FRAME - 1 && mFull) begin
            mDisp = mPend;
            mFull = 1'b0;
            mErr  = hasBad(mPend);
         end
         if (mAcc) begin
            mPend = in_sum;
            mFull = 1'b1;
         end
         mPos = (mPos + 1) % FRAME;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      numChecks++;
      if (got !== exp) begin
         numErrors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chkEn && !rst) begin
         checkOutput("seg",        32'(seg),        32'(expSeg));
         checkOutput("an",         32'(an),         32'(expAn));
         checkOutput("err",        32'(err),        32'(mErr));
         checkOutput("frame_done", 32'(frame_done), 32'(expFd));
         checkOutput("in_ready",   32'(in_ready),   32'(!mFull));
      end
   end

   // Drives inputs for the next rising edge, just after the falling edge.
   task automatic applyStimulus(input logic [16:0] v, input logic valid);
      @(negedge clk);
      #1;
      in_sum   = v;
      in_valid = valid;
   endtask

   // Offers a sum and holds it until accepted.
   task automatic sendSum(input logic [16:0] v);
      int n;
      n = 0;
      applyStimulus(v, 1'b1);
      while (!in_ready && n < 4 * FRAME) begin
         applyStimulus(v, 1'b1);
         n++;
      end
      if (!in_ready) checkOutput("send_stall", 32'(in_ready), 32'd1);
      applyStimulus(17'd0, 1'b0);
      checkOutput("ready_drop", 32'(in_ready), 32'd0);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(17'd0, 1'b0);
   endtask

   task automatic waitPos(input int pos);
      int n;
      n = 0;
      while (!(mPos == pos && in_ready) && n < 4 * FRAME) begin
         applyStimulus(17'd0, 1'b0);
         n++;
      end
      if (!(mPos == pos && in_ready)) checkOutput("wait_pos", 32'(in_ready), 32'd1);
   endtask

   function automatic logic [16:0] randSum();
      logic [16:0] v;
      int nd;
      if ($urandom_range(0, 9) == 0) return 17'($urandom);
      v  = '0;
      nd = $urandom_range(0, 5);
      for (int k = 0; k < 4; k++) begin
         if (k < nd) v[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      if (nd == 5) v[16] = 1'b1;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [16:0] curSum;
      logic        curValid;
      bit          rdyAtDrive;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_an",    32'(an),         32'd0);
      checkOutput("reset_seg",   32'(seg),        32'd0);
      checkOutput("reset_err",   32'(err),        32'd0);
      checkOutput("reset_fd",    32'(frame_done), 32'd0);
      checkOutput("reset_ready", 32'(in_ready),   32'd1);
      rst   = 1'b0;
      chkEn = 1'b1;

      $display("[TB] idle frames after reset");
      idle(2 * FRAME);

      $display("[TB] plain sum 1234+5678");
      sendSum(17'h06912);
      idle(2 * FRAME);

      $display("[TB] carry only, then a stalled second send");
      sendSum(17'h10000);
      sendSum(17'h00005);
      idle(2 * FRAME);

      $display("[TB] invalid nibble sets err, valid sum clears it");
      sendSum(17'h0A001);
      idle(2 * FRAME);
      checkOutput("err_set", 32'(err), 32'd1);
      sendSum(17'h00009);
      idle(2 * FRAME);
      checkOutput("err_clear", 32'(err), 32'd0);

      $display("[TB] reset mid-slot with pending data");
      sendSum(17'h0A001);
      idle(2 * FRAME);
      waitPos(1);
      sendSum(17'h06912);
      rst = 1'b1;
      #1;
      checkOutput("rst_an",    32'(an),       32'd0);
      checkOutput("rst_seg",   32'(seg),      32'd0);
      checkOutput("rst_err",   32'(err),      32'd0);
      checkOutput("rst_ready", 32'(in_ready), 32'd1);
      idle(2);
      rst = 1'b0;
      idle(3 * FRAME);

      $display("[TB] send exactly on a boundary cycle");
      waitPos(FRAME - 1);
      in_sum   = 17'h05555;
      in_valid = 1'b1;
      applyStimulus(17'd0, 1'b0);
      checkOutput("bnd_ready", 32'(in_ready), 32'd0);
      idle(3 * FRAME);

      $display("[TB] randomized traffic");
      curSum     = '0;
      curValid   = 1'b0;
      rdyAtDrive = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if (!curValid || rdyAtDrive) begin
            curValid = ($urandom_range(0, 3) == 0);
            curSum   = randSum();
         end
         if ($urandom_range(0, 399) == 0) begin
            rst      = 1'b1;
            curValid = 1'b0;
            idle(2);
            rst = 1'b0;
         end
         applyStimulus(curSum, curValid);
         rdyAtDrive = in_ready;
      end
      idle(2 * FRAME);

      $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
      $finish;
   end

endmodule

// File: doc/bcd_sum_display.md
Name: bcd_sum_display

Overview:
- Downstream consumer of the 4-digit BCD adder's 17-bit sum: 1 carry digit plus 4 BCD digits.
- Captures a sum through a valid/ready handshake and double-buffers it.
- Time-multiplexes the 5 digits onto one seven-segment bus with anti-ghosting gaps and leading-zero blanking.
- Sum updates are applied only at frame boundaries, so a displayed frame never mixes two sums.

Parameters:
- DIV_MAX, 49999: cycles per digit slot minus 1. Each slot is DIV_MAX+1 cycles. Legal range GAP+1 .. 2^20-1.
- GAP, 2: blank cycles at the start of each slot; `an` is all-zero during them. Legal range 0 .. DIV_MAX-1.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 displays all 5 digits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_sum  input  17  [16] carry digit, [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones
- in_valid  input  1  in_sum is valid this cycle
- in_ready  output  1  pending buffer is empty; equals !pending_full (combinational)
- seg  output  7  segments, active-high; seg[0]=a .. seg[6]=g
- an  output  5  one-hot digit enable, active-high; an[0]=ones .. an[4]=carry
- err  output  1  displayed value contains a nibble > 9
- frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async): prescaler=0, idx=0, pending_full=0, pending=0, disp=0, seg=0, an=0, err=0, frame_done=0. in_ready=1.
- Prescaler counts 0..DIV_MAX and wraps to 0. tick = (prescaler==DIV_MAX).
- idx advances on tick, 0→1→2→3→4→0.
- Frame boundary = tick && idx==4. Frame length is 5*(DIV_MAX+1) cycles.
- Accept: in_valid && in_ready. pending <= in_sum, pending_full <= 1. in_valid with in_ready low is ignored; the sender holds.
- Transfer: at a frame boundary with pending_full=1: disp <= pending, pending_full <= 0, err <= (any disp nibble [15:0] > 9).
- Accept in the same cycle as a boundary with pending empty: data goes to pending; transfer happens at the next boundary, no bypass.
- Slot FSM: GAP while prescaler < GAP, else SHOW. Returns to GAP on each tick.
- Digit value per idx: idx 0..3 → disp nibble idx; idx 4 → {3'b0, disp[16]}.
- Blanking (BLANK_LZ=1): digit k is blanked if it and every higher digit are zero. Digit 0 is never blanked.
- seg/an are registered, one-cycle latency from prescaler/idx:
  - GAP or blanked slot: an=0, seg=0.
  - SHOW: an = 1<<idx, seg = encode(digit).
- Encoding (hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. A–F → 40 (dash).
- frame_done: registered, high the cycle after each frame boundary.
- Reset mid-frame: everything returns to reset values; any pending data is discarded.

Optional Feature:
- Macro: BCD_DISP_DP_EN.
- Defined:
  - Adds input in_dp_pos[2:0], captured into pending alongside in_sum and moved to the display buffer alongside disp.
  - Adds output dp, active-high, registered like seg.
  - dp=1 during SHOW of slot idx == captured position. Positions 5–7 never light.
  - A digit holding the dp is never blanked.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan (bench uses DIV_MAX=3, GAP=1; frame = 20 cycles):
- Reset, then observe two frames → an=0, seg=0, err=0, in_ready=1. Slot for idx 0 shows seg=3F on an=00001. Other digits blanked. frame_done pulses every 20 cycles.
- Send in_sum=17'h06912 (1234+5678) → in_ready drops the next cycle. After the next boundary, slots show 2(5B), 1(06), 9(6F), 6(7D) on an 00001..01000. Slot 4 blanked. Each slot has 1 cycle with an=0 before the segment output.
- Send 17'h10000, then 17'h00005 while in_ready=0 → second send is stalled until the boundary. Frame shows carry 1(06) on an=10000 and zeros 3F on idx 0..3. The following frame shows 5 only.
- Send 17'h0A001 → err=1 after transfer. idx1 shows 3F, idx3 shows 40. Then send 17'h00009 → err returns to 0 at the next boundary.
- Assert rst mid-slot with pending_full=1 → an, seg and err clear immediately. in_ready=1. The old pending value is never displayed.
- Send with in_valid exactly at a boundary cycle → value appears only after the following boundary, not the current one.
